// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC generation, imem read, fetch queue; optional FETCH_PERF_EN perf counters
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          QUEUE_DEPTH = 4,
  parameter int          CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             isbranchtaken,
  input  logic [15:0]      branchpc,
  output logic             imem_req,
  output logic [15:0]      imem_addr,
  input  logic [15:0]      imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_pc,
  output logic [15:0]      out_instr,
  output logic [CNT_W-1:0] queue_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_flushed
`endif
);

  localparam int               PTR_W      = $clog2(QUEUE_DEPTH);
  localparam logic [CNT_W:0]   OCC_LIMIT  = (CNT_W+1)'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

  logic [15:0]      r_pc;
  logic [15:0]      r_req_pc;
  logic             r_inflight;
  logic [15:0]      r_q_pc    [QUEUE_DEPTH];
  logic [15:0]      r_q_instr [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [CNT_W:0]   w_occupancy;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;

  // Entries held plus the one response still on its way; issuing only below
  // the depth guarantees every response has a slot when it lands.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue     = !rst && !isbranchtaken && (w_occupancy < OCC_LIMIT);
  assign w_empty     = (r_count == '0);
  // A redirect discards the response arriving this cycle and empties the queue,
  // so neither push nor pop takes effect then.
  assign w_push      = r_inflight && !isbranchtaken;
  assign w_pop       = !w_empty && out_ready && !isbranchtaken;

  assign imem_req    = w_issue;
  assign imem_addr   = r_pc;
  assign out_valid   = !w_empty && !isbranchtaken;
  assign out_pc      = w_empty ? 16'h0000 : r_q_pc[r_head];
  assign out_instr   = w_empty ? 16'h0000 : r_q_instr[r_head];
  assign queue_count = r_count;

  // PC advance, redirect, and tracking of the single outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= 16'h0000;
      r_inflight <= 1'b0;
    end else if (isbranchtaken) begin
      r_pc       <= branchpc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc     <= r_pc + 16'h0001;
        r_req_pc <= r_pc;
      end
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk) begin
    if (rst || isbranchtaken) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are only visible through the head when non-empty
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_pc[r_tail]    <= r_req_pc;
      r_q_instr[r_tail] <= imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    w_push |-> (r_count != FULL_COUNT));

`ifdef FETCH_PERF_EN
  logic [32:0] w_fetched_sum;
  logic [32:0] w_flushed_sum;

  assign w_fetched_sum = {1'b0, perf_fetched} + 33'(w_push);
  assign w_flushed_sum = {1'b0, perf_flushed} + 33'(w_occupancy);

  // Saturating counts of pushed instructions and of work discarded by redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'h0000_0000;
      perf_flushed <= 32'h0000_0000;
    end else begin
      if (w_push)
        perf_fetched <= w_fetched_sum[32] ? 32'hFFFF_FFFF : w_fetched_sum[31:0];
      if (isbranchtaken)
        perf_flushed <= w_flushed_sum[32] ? 32'hFFFF_FFFF : w_flushed_sum[31:0];
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        isbranchtaken = 1'b0;
  logic [15:0] branchpc = 16'h0000;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_pc;
  logic [15:0] out_instr;
  logic [2:0]  queue_count;

  int          n_pass = 0;
  int          n_total = 0;
  bit          mon_en = 1'b0;
  exp_t        sb[$];
  logic [15:0] issued[$];
  exp_t        mon_e;

  fetch_unit #(.RESET_PC(16'h0000), .QUEUE_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .isbranchtaken(isbranchtaken), .branchpc(branchpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  // instruction memory: one-cycle read, contents = address ^ A5A5
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ 16'hA5A5) : 16'hDEAD;

  // log every issued address
  always @(negedge clk) if (imem_req) issued.push_back(imem_addr);

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(logic [15:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc ^ 16'hA5A5;
    return e;
  endfunction

  // monitor: every accepted head is compared against the scoreboard
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: unexpected out_pc %h with nothing expected", out_pc);
      end else begin
        mon_e = sb.pop_front();
        check("out_pc", {16'h0, out_pc}, {16'h0, mon_e.pc});
        check("out_instr", {16'h0, out_instr}, {16'h0, mon_e.instr});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; isbranchtaken = 1'b0; branchpc = 16'h0000; out_ready = 1'b0; mon_en = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_count", {29'h0, queue_count}, 32'h0);
    check("rst_out_pc", {16'h0, out_pc}, 32'h0);
    check("rst_out_instr", {16'h0, out_instr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    issued.delete();
  endtask

  task automatic drain(string name, int budget);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1; mon_en = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    out_ready = 1'b0; mon_en = 1'b0;
    check({name, "_drained"}, {31'h0, done}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // sequential streaming from reset
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    check("t1_first_req", {31'h0, imem_req}, 32'h1);
    check("t1_first_addr", {16'h0, imem_addr}, 32'h0);
    check("t1_first_valid", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 8; i++) sb.push_back(mk(16'(i)));
    drain("t1", 20);

    // back-pressure fills the queue and stalls issue
    do_reset();
    repeat (12) @(negedge clk);
    check("t2_count_full", {29'h0, queue_count}, 32'd4);
    check("t2_req_stalled", {31'h0, imem_req}, 32'h0);
    check("t2_head_valid", {31'h0, out_valid}, 32'h1);
    check("t2_head_pc", {16'h0, out_pc}, 32'h0);
    check("t2_issued_n", issued.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("t2_issued_addr", {16'h0, issued[i]}, i);

    // redirect with a full queue
    @(posedge clk); #1;
    isbranchtaken = 1'b1; branchpc = 16'h0040;
    @(negedge clk);
    check("t3_valid_forced", {31'h0, out_valid}, 32'h0);
    check("t3_req_blocked", {31'h0, imem_req}, 32'h0);
    @(posedge clk); #1;
    isbranchtaken = 1'b0;
    @(negedge clk);
    check("t3_count_flushed", {29'h0, queue_count}, 32'h0);
    check("t3_req_t1", {31'h0, imem_req}, 32'h1);
    check("t3_addr_t1", {16'h0, imem_addr}, 32'h0040);
    @(negedge clk);
    check("t3_valid_t2", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    check("t3_valid_t3", {31'h0, out_valid}, 32'h1);
    check("t3_pc_t3", {16'h0, out_pc}, 32'h0040);
    for (int i = 0; i < 6; i++) sb.push_back(mk(16'h0040 + 16'(i)));
    drain("t3", 20);

    // redirect while the request for 0x0005 is outstanding
    do_reset();
    for (int i = 0; i < 4; i++) sb.push_back(mk(16'(i)));
    for (int i = 0; i < 3; i++) sb.push_back(mk(16'h0100 + 16'(i)));
    out_ready = 1'b1; mon_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 16'h0005) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_saw_req5", {31'h0, found}, 32'h1);
    @(posedge clk); #1;
    isbranchtaken = 1'b1; branchpc = 16'h0100;
    @(negedge clk);
    check("t4_req_blocked", {31'h0, imem_req}, 32'h0);
    @(posedge clk); #1;
    isbranchtaken = 1'b0;
    drain("t4", 20);

    // PC wrap from 0xFFFF to 0x0000
    do_reset();
    isbranchtaken = 1'b1; branchpc = 16'hFFFF;
    @(posedge clk); #1;
    isbranchtaken = 1'b0;
    sb.push_back(mk(16'hFFFF));
    sb.push_back(mk(16'h0000));
    sb.push_back(mk(16'h0001));
    drain("t5", 20);

    // reset mid-stream overrides a simultaneous redirect
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (queue_count == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_saw_count3", {31'h0, found}, 32'h1);
    rst = 1'b1; isbranchtaken = 1'b1; branchpc = 16'h0200;
    @(posedge clk); #1;
    rst = 1'b0; isbranchtaken = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t6_count", {29'h0, queue_count}, 32'h0);
    check("t6_valid", {31'h0, out_valid}, 32'h0);
    check("t6_req", {31'h0, imem_req}, 32'h1);
    check("t6_addr", {16'h0, imem_addr}, 32'h0);
    for (int i = 0; i < 3; i++) sb.push_back(mk(16'(i)));
    drain("t6", 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
